layer_seq_ctrl: RTL and testbench

Layer/frame sequencer directly upstream of the feature-map guard-generation controller. Holds a small descriptor table (one entry per layer) and, on `start`, walks frames × layers. For each pair it issues one descriptor over the `ctrl_valid`/`ctrl_ready` handshake, then waits for the downstream `ctrl_finish` pulse before issuing the next. It derives `is_first` and `is_diff` per frame, so the first frame always runs dense and later frames run differential where enabled.

---
 rtl/layer_seq_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: walks frames x layers over a small descriptor table.
//
// Each (frame, layer) pair gets one descriptor over ctrl_valid/ctrl_ready.
// The controller then waits for the ctrl_finish pulse before issuing the next
// pair. The first frame always runs dense. Later frames run differential
// wherever the entry's diff_en bit is set.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_we/addr/wdata descriptor table write (IDLE only), wdata packed as
//                     {diff_en, kernel_mode, co, c, h, w}
//   start             one-cycle run request; layer_num/frame_num sampled here
//   abort             finish the current layer, then stop
//   busy/done         status; done is a one-cycle end-of-run pulse
//   desc_err          sticky: a descriptor with a zero dimension was skipped
//   layer_idx/frame_idx current position in the walk
//   ctrl_*            descriptor handshake and layer-complete pulse
//   *_o               registered descriptor fields and flags
module layer_seq_ctrl #(
  parameter int unsigned LAYER_MAX = 8,
  parameter int unsigned LW        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [LW-1:0]   cfg_addr,
  input  logic [33:0]     cfg_wdata,
  input  logic            start,
  input  logic [LW:0]     layer_num,
  input  logic [7:0]      frame_num,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            desc_err,
  output logic [LW-1:0]   layer_idx,
  output logic [7:0]      frame_idx,
  output logic            ctrl_valid,
  input  logic            ctrl_ready,
  input  logic            ctrl_finish,
  output logic [7:0]      w_num_o,
  output logic [7:0]      h_num_o,
  output logic [7:0]      c_num_o,
  output logic [7:0]      co_num_o,
  output logic            kernel_mode_o,
  output logic            bit_mode_o,
  output logic            is_diff_o,
  output logic            is_first_o
);

  localparam int unsigned CW = LW + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [LW:0]   layer_num_q, layer_num_d;
  logic [7:0]    frame_num_q, frame_num_d;
  logic [LW-1:0] layer_idx_q, layer_idx_d;
  logic [7:0]    frame_idx_q, frame_idx_d;
  logic          abort_q, abort_d;
  logic          desc_err_q, desc_err_d;
  logic [7:0]    w_q, w_d, h_q, h_d, c_q, c_d, co_q, co_d;
  logic          kmode_q, kmode_d, diff_q, diff_d, first_q, first_d;
  logic          valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  // Descriptor table is deliberately left out of reset so a restart after
  // rst reuses the previously written entries.
  logic [33:0]   tbl_q [LAYER_MAX];
  logic [33:0]   entry;

  logic [LW:0]   layer_last;
  logic          last_layer, last_frame, run_done, zero_dim;
  logic [LW-1:0] adv_layer;
  logic [7:0]    adv_frame;

  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == StIdle)) begin
      tbl_q[cfg_addr] <= cfg_wdata;
    end
  end

  assign entry      = tbl_q[layer_idx_q];
  assign zero_dim   = (entry[7:0] == 8'd0) || (entry[15:8] == 8'd0) ||
                      (entry[23:16] == 8'd0) || (entry[31:24] == 8'd0);
  assign layer_last = layer_num_q - CW'(1);
  assign last_layer = ({1'b0, layer_idx_q} == layer_last);
  assign last_frame = (frame_idx_q == (frame_num_q - 8'd1));
  assign run_done   = last_layer && last_frame;

  // Index advance shared by the skip path in LOAD and by finish in WAIT.
  always_comb begin
    adv_layer = layer_idx_q + LW'(1);
    adv_frame = frame_idx_q;
    if (last_layer) begin
      adv_layer = '0;
      adv_frame = frame_idx_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_num_d = layer_num_q;
    frame_num_d = frame_num_q;
    layer_idx_d = layer_idx_q;
    frame_idx_d = frame_idx_q;
    desc_err_d  = desc_err_q;
    abort_d     = abort_q | (abort && (state_q != StIdle));
    w_d         = w_q;
    h_d         = h_q;
    c_d         = c_q;
    co_d        = co_q;
    kmode_d     = kmode_q;
    diff_d      = diff_q;
    first_d     = first_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          layer_num_d = layer_num;
          frame_num_d = frame_num;
          layer_idx_d = '0;
          frame_idx_d = '0;
          desc_err_d  = 1'b0;
          abort_d     = 1'b0;
          state_d     = ((layer_num == '0) || (frame_num == 8'd0)) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (abort || abort_q) begin
          state_d = StDone;
        end else if (zero_dim) begin
          desc_err_d  = 1'b1;
          layer_idx_d = adv_layer;
          frame_idx_d = adv_frame;
          if (run_done) state_d = StDone;
        end else begin
          w_d     = entry[7:0];
          h_d     = entry[15:8];
          c_d     = entry[23:16];
          co_d    = entry[31:24];
          kmode_d = entry[32];
          diff_d  = entry[33] && (frame_idx_q != 8'd0);
          first_d = (frame_idx_q == 8'd0);
          state_d = StIssue;
        end
      end
      StIssue: begin
        // A handshake in the same cycle as abort still completes the layer.
        if (ctrl_ready) begin
          state_d = StWait;
        end else if (abort || abort_q) begin
          state_d = StDone;
        end
      end
      StWait: begin
        if (ctrl_finish) begin
          layer_idx_d = adv_layer;
          frame_idx_d = adv_frame;
          state_d     = (run_done || abort_d) ? StDone : StLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    valid_d = (state_d == StIssue);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      layer_num_q <= '0;
      frame_num_q <= '0;
      layer_idx_q <= '0;
      frame_idx_q <= '0;
      abort_q     <= 1'b0;
      desc_err_q  <= 1'b0;
      w_q         <= '0;
      h_q         <= '0;
      c_q         <= '0;
      co_q        <= '0;
      kmode_q     <= 1'b0;
      diff_q      <= 1'b0;
      first_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_num_q <= layer_num_d;
      frame_num_q <= frame_num_d;
      layer_idx_q <= layer_idx_d;
      frame_idx_q <= frame_idx_d;
      abort_q     <= abort_d;
      desc_err_q  <= desc_err_d;
      w_q         <= w_d;
      h_q         <= h_d;
      c_q         <= c_d;
      co_q        <= co_d;
      kmode_q     <= kmode_d;
      diff_q      <= diff_d;
      first_q     <= first_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign desc_err      = desc_err_q;
  assign layer_idx     = layer_idx_q;
  assign frame_idx     = frame_idx_q;
  assign ctrl_valid    = valid_q;
  assign w_num_o       = w_q;
  assign h_num_o       = h_q;
  assign c_num_o       = c_q;
  assign co_num_o      = co_q;
  assign kernel_mode_o = kmode_q;
  assign bit_mode_o    = 1'b0;
  assign is_diff_o     = diff_q;
  assign is_first_o    = first_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: table-driven runs, hand-written corner sequences
// and randomized runs checked against a frame/layer walk model.
module tb_layer_seq_ctrl;

  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst, cfg_we, start, abort, ctrl_ready, ctrl_finish;
  logic [LW-1:0] cfg_addr;
  logic [33:0]   cfg_wdata;
  logic [LW:0]   layer_num;
  logic [7:0]    frame_num;
  logic          busy, done, desc_err, ctrl_valid;
  logic [LW-1:0] layer_idx;
  logic [7:0]    frame_idx, w_num_o, h_num_o, c_num_o, co_num_o;
  logic          kernel_mode_o, bit_mode_o, is_diff_o, is_first_o;

  layer_seq_ctrl #(.LAYER_MAX(8), .LW(LW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .layer_num(layer_num), .frame_num(frame_num), .abort(abort),
    .busy(busy), .done(done), .desc_err(desc_err), .layer_idx(layer_idx),
    .frame_idx(frame_idx), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ctrl_finish(ctrl_finish), .w_num_o(w_num_o), .h_num_o(h_num_o), .c_num_o(c_num_o),
    .co_num_o(co_num_o), .kernel_mode_o(kernel_mode_o), .bit_mode_o(bit_mode_o),
    .is_diff_o(is_diff_o), .is_first_o(is_first_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] w, h, c, co;
    logic       km, bm, diff, first;
    logic [2:0] l;
    logic [7:0] f;
  } desc_t;

  typedef struct {
    int ln;
    int fn;
    int hs;
    int err;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] tb_w [8], tb_h [8], tb_c [8], tb_co [8];
  logic       tb_km [8], tb_de [8];

  desc_t obs_q[$];
  desc_t exp_q[$];
  int    exp_err;
  int    dn, busy_cnt, first_v, last_fin, done_slot;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic write_desc(input int a, input int w, input int h, input int c, input int co,
                            input bit km, input bit de);
    cfg_we    = 1'b1;
    cfg_addr  = LW'(a);
    cfg_wdata = {de, km, 8'(co), 8'(c), 8'(h), 8'(w)};
    tick();
    cfg_we    = 1'b0;
    tb_w[a] = 8'(w); tb_h[a] = 8'(h); tb_c[a] = 8'(c); tb_co[a] = 8'(co);
    tb_km[a] = km; tb_de[a] = de;
  endtask

  function automatic desc_t cur_desc();
    desc_t d;
    d.w = w_num_o; d.h = h_num_o; d.c = c_num_o; d.co = co_num_o;
    d.km = kernel_mode_o; d.bm = bit_mode_o; d.diff = is_diff_o; d.first = is_first_o;
    d.l = layer_idx; d.f = frame_idx;
    return d;
  endfunction

  // Expected issue order: every (frame, layer) pair in order, skipping entries
  // with a zero dimension.
  function automatic void model(input int ln, input int fn);
    desc_t d;
    exp_q.delete();
    exp_err = 0;
    for (int f = 0; f < fn; f++) begin
      for (int l = 0; l < ln; l++) begin
        if (tb_w[l] == 0 || tb_h[l] == 0 || tb_c[l] == 0 || tb_co[l] == 0) begin
          exp_err = 1;
        end else begin
          d.w = tb_w[l]; d.h = tb_h[l]; d.c = tb_c[l]; d.co = tb_co[l];
          d.km = tb_km[l]; d.bm = 1'b0; d.diff = tb_de[l] && (f != 0);
          d.first = (f == 0); d.l = 3'(l); d.f = 8'(f);
          exp_q.push_back(d);
        end
      end
    end
  endfunction

  // Start a run and act as downstream until the sequencer is idle again.
  // Slot 0 is the first observation after the edge that sampled start.
  task automatic run(input int ln, input int fn, input bit rnd, input int lat);
    int fin_cnt;
    int s;
    obs_q.delete();
    dn = 0; busy_cnt = 0; first_v = -1; last_fin = -1; done_slot = -1;
    fin_cnt = -1;
    layer_num = (LW + 1)'(ln);
    frame_num = 8'(fn);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = 0;
    while (busy && s < 4000) begin
      busy_cnt++;
      if (done) begin dn++; done_slot = s; end
      if (ctrl_valid && first_v < 0) first_v = s;
      ctrl_finish = 1'b0;
      if (fin_cnt == 0) begin
        ctrl_finish = 1'b1; last_fin = s; fin_cnt = -1;
      end else if (fin_cnt > 0) begin
        fin_cnt--;
      end
      ctrl_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ctrl_valid && ctrl_ready) begin
        obs_q.push_back(cur_desc());
        fin_cnt = rnd ? int'($urandom_range(0, 5)) : lat;
      end
      tick();
      s++;
    end
    ctrl_finish = 1'b0;
    ctrl_ready  = 1'b0;
    check("run_terminates", 64'(s < 4000), 64'd1);
  endtask

  task automatic compare_obs(input string tag);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_desc"}, 64'(obs_q[i]), 64'(exp_q[i]));
    end
  endtask

  vec_t vecs[9];
  int   ln_r, fn_r;

  initial begin
    vecs[0] = '{ln: 2, fn: 3, hs: 6, err: 0};
    vecs[1] = '{ln: 0, fn: 5, hs: 0, err: 0};
    vecs[2] = '{ln: 3, fn: 0, hs: 0, err: 0};
    vecs[3] = '{ln: 4, fn: 2, hs: 6, err: 1};
    vecs[4] = '{ln: 8, fn: 1, hs: 6, err: 1};
    vecs[5] = '{ln: 1, fn: 4, hs: 4, err: 0};
    vecs[6] = '{ln: 6, fn: 1, hs: 4, err: 1};
    vecs[7] = '{ln: 5, fn: 2, hs: 8, err: 1};
    vecs[8] = '{ln: 3, fn: 3, hs: 9, err: 0};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    layer_num = '0; frame_num = '0; abort = 1'b0; ctrl_ready = 1'b0; ctrl_finish = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tb_w[i] = '0; tb_h[i] = '0; tb_c[i] = '0; tb_co[i] = '0; tb_km[i] = 0; tb_de[i] = 0;
    end
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", {busy, done, desc_err, ctrl_valid, layer_idx, frame_idx, w_num_o,
          h_num_o, c_num_o, co_num_o, kernel_mode_o, bit_mode_o, is_diff_o, is_first_o}, '0);

    // Two layers x three frames, finish ten cycles after each handshake.
    write_desc(0, 24, 8, 4, 4, 1'b0, 1'b1);
    write_desc(1, 24, 8, 4, 4, 1'b0, 1'b1);
    run(2, 3, 1'b0, 9);
    model(2, 3);
    compare_obs("basic");
    check("basic_done_count", 64'(dn), 64'd1);
    check("basic_first_valid", 64'(first_v), 64'd1);
    check("basic_done_after_finish", 64'(done_slot), 64'(last_fin + 1));
    check("basic_desc_err", 64'(desc_err), 64'd0);

    // Ready held low: valid and fields stay put, handshake on first ready.
    layer_num = 4'd1; frame_num = 8'd1; start = 1'b1;
    tick();
    start = 1'b0; ctrl_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", {ctrl_valid, w_num_o, h_num_o, c_num_o, co_num_o, is_first_o,
            is_diff_o}, {1'b1, 8'd24, 8'd8, 8'd4, 8'd4, 1'b1, 1'b0});
      tick();
    end
    check("stall_valid_before_ready", 64'(ctrl_valid), 64'd1);
    ctrl_ready = 1'b1;
    tick();
    check("stall_valid_drop", 64'(ctrl_valid), 64'd0);
    ctrl_ready = 1'b0; ctrl_finish = 1'b1;
    tick();
    ctrl_finish = 1'b0;
    check("stall_done", 64'(done), 64'd1);
    tick();

    // Zero-dimension entry in the middle is skipped.
    write_desc(1, 24, 0, 4, 4, 1'b0, 1'b1);
    write_desc(2, 10, 5, 2, 2, 1'b1, 1'b0);
    run(3, 1, 1'b0, 2);
    model(3, 1);
    compare_obs("skip");
    check("skip_desc_err", 64'(desc_err), 64'd1);
    check("skip_done", 64'(dn), 64'd1);

    // frame_num = 0 finishes immediately.
    run(2, 0, 1'b0, 2);
    check("zero_frames_hs", 64'(obs_q.size()), 64'd0);
    check("zero_frames_done_slot", 64'(done_slot), 64'd0);
    check("zero_frames_busy_cycles", 64'(busy_cnt), 64'd1);

    // Abort during WAIT, with a stray start that must be ignored.
    layer_num = 4'd1; frame_num = 8'd3; start = 1'b1;
    tick();
    start = 1'b0; ctrl_ready = 1'b1;
    tick();
    check("abort_valid", 64'(ctrl_valid), 64'd1);
    tick();
    ctrl_ready = 1'b0;
    check("abort_in_wait", 64'(ctrl_valid), 64'd0);
    abort = 1'b1; start = 1'b1; layer_num = 4'd0; frame_num = 8'd0;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_still_busy", {busy, done}, 2'b10);
    ctrl_finish = 1'b1;
    tick();
    ctrl_finish = 1'b0;
    check("abort_done", {done, ctrl_valid}, 2'b10);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("abort_no_valid", {ctrl_valid, busy}, 2'b00);
    end

    // Reset during ISSUE, then restart on the preserved table.
    layer_num = 4'd3; frame_num = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_issue_valid", 64'(ctrl_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outputs", {busy, done, desc_err, ctrl_valid, layer_idx, frame_idx, w_num_o,
          h_num_o, c_num_o, co_num_o, kernel_mode_o, is_diff_o, is_first_o}, '0);
    run(3, 2, 1'b0, 3);
    model(3, 2);
    compare_obs("restart");
    check("restart_desc_err", 64'(desc_err), 64'(exp_err));

    // Table-driven runs over a fixed table with entries 3 (c) and 5 (co) bad.
    for (int i = 0; i < 8; i++) begin
      write_desc(i, 8 + i, 4 + i, (i == 3) ? 0 : 2, (i == 5) ? 0 : 3, 1'(i), 1'(i >> 1));
    end
    foreach (vecs[v]) begin
      run(vecs[v].ln, vecs[v].fn, 1'b0, 2);
      check("vec_handshakes", 64'(obs_q.size()), 64'(vecs[v].hs));
      check("vec_desc_err", 64'(desc_err), 64'(vecs[v].err));
      check("vec_done", 64'(dn), 64'd1);
      model(vecs[v].ln, vecs[v].fn);
      compare_obs("vec");
    end

    // Random tables, counts and downstream timing.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 8; i++) begin
        write_desc(i,
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      ln_r = int'($urandom_range(0, 8));
      fn_r = int'($urandom_range(0, 4));
      run(ln_r, fn_r, 1'b1, 0);
      model(ln_r, fn_r);
      compare_obs("rand");
      check("rand_desc_err", 64'(desc_err), 64'(exp_err));
      check("rand_done", 64'(dn), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
